// File: rtl/byte_serializer.sv
// byte_serializer
//   Drives an 8-to-1 bit MUX so that its output becomes a serial bitstream. Bytes are
//   accepted on a valid/ready handshake, held on mux_datain, and mux_sel is stepped
//   through all 8 bit positions, each held for CLKS_PER_BIT cycles.
//
// Parameters
//   CLKS_PER_BIT  cycles each sel value is held (1..65535)
//   MSB_FIRST     0: sel steps 0->7, 1: sel steps 7->0
//   GAP_CYCLES    idle cycles forced after each byte; 0 allows back-to-back bytes
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous active-high reset
//   din         byte to serialize, sampled when din_valid & din_ready
//   din_valid   producer has a byte
//   din_ready   block accepts din this cycle
//   mux_datain  latched byte for the MUX datain
//   mux_sel     current bit index for the MUX sel
//   bit_strobe  1-cycle pulse on the first cycle of each new sel value
//   busy        high while a byte is being stepped out
//   byte_done   1-cycle pulse in the cycle after a byte's last bit period
module byte_serializer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          MSB_FIRST    = 1'b0,
    parameter int unsigned GAP_CYCLES   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] mux_datain,
    output logic [2:0] mux_sel,
    output logic       bit_strobe,
    output logic       busy,
    output logic       byte_done
);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    localparam logic [15:0] TickLast = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  SelFirst = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [31:0] GapLast  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] tick_q, tick_d;
    logic [31:0] gap_q, gap_d;
    logic        strobe_q, strobe_d;
    logic        done_q, done_d;

    logic last_cycle;
    logic accept;

    // Final tick of bit 7: the only SHIFT cycle in which a new byte may be taken.
    assign last_cycle = (state_q == StShift) && (bit_q == 3'd7) && (tick_q == TickLast);
    assign din_ready  = (state_q == StIdle) || (last_cycle && (GAP_CYCLES == 0));
    assign accept     = din_valid && din_ready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        bit_d    = bit_q;
        tick_d   = tick_q;
        gap_d    = gap_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: ;
            StShift: begin
                if (tick_q == TickLast) begin
                    tick_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        done_d = 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StGap;
                            gap_d   = 32'd0;
                        end
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        sel_d    = MSB_FIRST ? (sel_q - 3'd1) : (sel_q + 3'd1);
                        strobe_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 16'd1;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Acceptance (from IDLE or back-to-back) overrides the end-of-byte transition.
        if (accept) begin
            state_d  = StShift;
            data_d   = din;
            sel_d    = SelFirst;
            bit_d    = 3'd0;
            tick_d   = 16'd0;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            data_q   <= 8'd0;
            sel_q    <= 3'd0;
            bit_q    <= 3'd0;
            tick_q   <= 16'd0;
            gap_q    <= 32'd0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            bit_q    <= bit_d;
            tick_q   <= tick_d;
            gap_q    <= gap_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign mux_datain = data_q;
    assign mux_sel    = sel_q;
    assign bit_strobe = strobe_q;
    assign byte_done  = done_q;
    assign busy       = (state_q == StShift);

endmodule
